// File: rtl/fir_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// fir_ctrl_pkg
// Shared types and constants for the FIR stream controller.
//   ctrl_state_t : controller FSM states (IDLE, CLR, LOAD, RUN, FLUSH)
//   DW_DEF       : default sample/coefficient width
//   RW_DEF       : default result width
//   res_w()      : result width for a given sample width
// -----------------------------------------------------------------------------
package fir_ctrl_pkg;

  localparam int DW_DEF = 16;
  localparam int RW_DEF = 2 * DW_DEF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLR   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_FLUSH = 3'd4
  } ctrl_state_t;

  // Full-precision product width of two dw-bit signed operands.
  function automatic int res_w(input int dw);
    return 2 * dw;
  endfunction

endpackage

// File: rtl/fir_stream_ctrl_if.sv
// -----------------------------------------------------------------------------
// fir_stream_ctrl_if
// Stream-side signals of the FIR controller: coefficient config port, sample
// input port, result output port, plus flush/cfg_go requests and busy status.
//
// Handshake rule for every valid/ready pair (cfg, s, m): a word transfers on a
// rising clk edge where valid && ready are both high. The producer holds valid
// and its data stable until the transfer; ready may depend on valid-independent
// state and on the consumer's own inputs, never on valid of the same pair.
//
// Modports:
//   slave  : the controller (consumes cfg/s, produces m)
//   master : the surrounding source/sink
// -----------------------------------------------------------------------------
interface fir_stream_ctrl_if
  import fir_ctrl_pkg::*;
#(
  parameter int DW = DW_DEF
);

  logic              cfg_go;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [DW-1:0]     cfg_coeff;
  logic              s_valid;
  logic              s_ready;
  logic [DW-1:0]     s_data;
  logic              flush;
  logic              m_valid;
  logic              m_ready;
  logic [2*DW-1:0]   m_data;
  logic              busy;

  modport slave (
    input  cfg_go, cfg_valid, cfg_coeff, s_valid, s_data, flush, m_ready,
    output cfg_ready, s_ready, m_valid, m_data, busy
  );

  modport master (
    output cfg_go, cfg_valid, cfg_coeff, s_valid, s_data, flush, m_ready,
    input  cfg_ready, s_ready, m_valid, m_data, busy
  );

endinterface

// File: rtl/fir_token_pipe.sv
// -----------------------------------------------------------------------------
// fir_token_pipe
// Tracks which FIR advance pulses carried a real sample. A token enters at the
// head on every enable (tok_in=1 for a real sample, 0 for a flush pulse) and
// leaves the tail on the LATENCY-th enable counting its own; at that moment the
// FIR output holds the result of that sample.
//
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   en        : FIR advance strobe (fir_start)
//   tok_in    : 1 when the advancing word is a real sample
//   take      : the controller has captured a result that left the tail
//   tail_out  : this enable shifts a token out of the tail (combinational)
//   pipe_any  : at least one token still waiting inside the stages
//   count     : tokens inserted and not yet taken (never exceeds LATENCY)
//
// Only LATENCY-1 stages are stored: the token's own pulse is the first of the
// LATENCY pulses, and the slot after the tail is the controller's
// result-pending flag, so count spans LATENCY slots in total.
// LATENCY must be at least 2.
// -----------------------------------------------------------------------------
module fir_token_pipe
  import fir_ctrl_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int CW      = $clog2(LATENCY + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          tok_in,
  input  logic          take,
  output logic          tail_out,
  output logic          pipe_any,
  output logic [CW-1:0] count
);

  localparam int D = LATENCY - 1;

  logic [D-1:0] stage;

  assign tail_out = en && stage[D-1];
  assign pipe_any = |stage;

  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
      count <= '0;
    end else begin
      if (en) begin
        stage[0] <= tok_in;
        for (int i = 1; i < D; i++) begin
          stage[i] <= stage[i-1];
        end
      end
      count <= count + CW'(en && tok_in) - CW'(take);
    end
  end

endmodule

// File: rtl/fir_stream_ctrl.sv
// -----------------------------------------------------------------------------
// fir_stream_ctrl
// Sequencer for the symmetric pipelined FIR datapath. Loads NTAPS coefficients
// through the cfg port, then advances the filter once per accepted sample and
// returns each sample's result, in order, on the m port. It is the only driver
// of the FIR control pins.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   bus (slave)     : cfg_go, cfg_valid/cfg_ready/cfg_coeff, s_valid/s_ready/
//                     s_data, flush, m_valid/m_ready/m_data, busy
//   fir_rst         : one-cycle clear pulse to the FIR (index and taps)
//   fir_load_coeff  : FIR coefficient write strobe
//   fir_coeff       : FIR coefficient data
//   fir_start       : FIR advance strobe
//   fir_x           : FIR sample data
//   fir_y           : FIR result
//   dbg_state       : current FSM state
// -----------------------------------------------------------------------------
module fir_stream_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int NTAPS   = 100,
  parameter int LATENCY = 4,
  parameter int DW      = DW_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  fir_stream_ctrl_if.slave      bus,
  output logic                  fir_rst,
  output logic                  fir_load_coeff,
  output logic [DW-1:0]         fir_coeff,
  output logic                  fir_start,
  output logic [DW-1:0]         fir_x,
  input  logic [res_w(DW)-1:0]  fir_y,
  output ctrl_state_t           dbg_state
);

  localparam int RW = res_w(DW);
  localparam int CW = $clog2(LATENCY + 1);
  localparam int LW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
  localparam logic [LW-1:0] LD_LAST = LW'(NTAPS - 1);

  ctrl_state_t   state;
  logic          loaded;
  logic [LW-1:0] ld_cnt;
  logic          hold_full;
  logic [RW-1:0] hold_data;
  // fir_y holds a result that has left the token tail but is not yet captured.
  // fir_y only changes on fir_start, so the result waits safely there.
  logic          res_pend;

  logic          tail_out;
  logic          pipe_any;
  logic [CW-1:0] tok_cnt;

  logic          run_like;
  logic          hold_accept;
  logic          cfg_hs;
  logic          s_rdy;
  logic          s_hs;
  logic          flush_start;
  logic          capture;

  // ---------------------------------------------------------------------------
  // Handshake / strobe decode
  // ---------------------------------------------------------------------------
  // After the first load, IDLE streams exactly like RUN.
  assign run_like    = (state == ST_RUN) || ((state == ST_IDLE) && loaded);
  // The hold register can take a new result this cycle (empty or being popped).
  assign hold_accept = !hold_full || bus.m_ready;
  assign cfg_hs      = bus.cfg_valid && (state == ST_LOAD);
  // In IDLE a cfg_go wins over streaming so no token slips in ahead of CLR.
  assign s_rdy       = run_like && hold_accept && !((state == ST_IDLE) && bus.cfg_go);
  assign s_hs        = bus.s_valid && s_rdy;
  // Zero pulses only while real tokens still sit in the stages.
  assign flush_start = (state == ST_FLUSH) && pipe_any && hold_accept;
  assign capture     = res_pend && hold_accept;

  assign fir_start      = s_hs || flush_start;
  assign fir_x          = s_hs ? bus.s_data : '0;
  assign fir_load_coeff = cfg_hs;
  assign fir_coeff      = cfg_hs ? bus.cfg_coeff : '0;
  assign fir_rst        = (state == ST_CLR);

  assign bus.cfg_ready = (state == ST_LOAD);
  assign bus.s_ready   = s_rdy;
  assign bus.m_valid   = hold_full;
  assign bus.m_data    = hold_data;
  assign bus.busy      = !(((state == ST_IDLE) || (state == ST_RUN)) && (tok_cnt == '0));

  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Token tracking
  // ---------------------------------------------------------------------------
  fir_token_pipe #(
    .LATENCY (LATENCY),
    .CW      (CW)
  ) u_token_pipe (
    .clk      (clk),
    .rst      (rst),
    .en       (fir_start),
    .tok_in   (s_hs),
    .take     (capture),
    .tail_out (tail_out),
    .pipe_any (pipe_any),
    .count    (tok_cnt)
  );

  // ---------------------------------------------------------------------------
  // FSM, load counter and result hold register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      loaded    <= 1'b0;
      ld_cnt    <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
      res_pend  <= 1'b0;
    end else begin
      // Capture and pop may coincide; the new result then replaces the old.
      if (capture) begin
        hold_data <= fir_y;
        hold_full <= 1'b1;
      end else if (hold_full && bus.m_ready) begin
        hold_full <= 1'b0;
      end

      // A tail exit only happens on fir_start, which already required
      // hold_accept, so a pending result is always captured at that same edge.
      res_pend <= tail_out || (res_pend && !capture);

      case (state)
        ST_IDLE: begin
          if (bus.cfg_go && (tok_cnt == '0)) begin
            state <= ST_CLR;
          end else if (loaded && bus.flush && (tok_cnt != '0)) begin
            state <= ST_FLUSH;
          end
        end
        ST_CLR: begin
          ld_cnt <= '0;
          loaded <= 1'b0;
          state  <= ST_LOAD;
        end
        ST_LOAD: begin
          if (cfg_hs) begin
            ld_cnt <= ld_cnt + 1'b1;
            if (ld_cnt == LD_LAST) begin
              loaded <= 1'b1;
              state  <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          // cfg_go with tokens in flight is dropped, not remembered.
          if (bus.cfg_go && (tok_cnt == '0)) begin
            state <= ST_IDLE;
          end else if (bus.flush && (tok_cnt != '0)) begin
            state <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if ((tok_cnt == '0) && !hold_full) begin
            state <= ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fir_stream_ctrl
// Directed bench for fir_stream_ctrl with a behavioural pipelined FIR stand-in.
// Coefficients are all 1, so each result is the running sum of the samples
// pushed since the last FIR clear.
// -----------------------------------------------------------------------------
module tb_fir_stream_ctrl;
  import fir_ctrl_pkg::*;

  localparam int NTAPS   = 100;
  localparam int LATENCY = 4;
  localparam int DW      = 16;
  localparam int RW      = 2 * DW;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fir_stream_ctrl_if #(.DW(DW)) bus ();

  logic          fir_rst;
  logic          fir_load_coeff;
  logic [DW-1:0] fir_coeff;
  logic          fir_start;
  logic [DW-1:0] fir_x;
  logic [RW-1:0] fir_y;
  ctrl_state_t   dbg_state;

  fir_stream_ctrl #(
    .NTAPS   (NTAPS),
    .LATENCY (LATENCY),
    .DW      (DW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .bus            (bus),
    .fir_rst        (fir_rst),
    .fir_load_coeff (fir_load_coeff),
    .fir_coeff      (fir_coeff),
    .fir_start      (fir_start),
    .fir_x          (fir_x),
    .fir_y          (fir_y),
    .dbg_state      (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // FIR stand-in: result of a sample appears on fir_y after LATENCY advances,
  // counting the sample's own advance.
  // ---------------------------------------------------------------------------
  logic signed [DW-1:0] coef [NTAPS];
  logic signed [DW-1:0] hist [NTAPS];
  logic signed [RW-1:0] rp   [LATENCY];
  logic signed [RW-1:0] acc;
  logic signed [DW-1:0] xs;
  int                   widx;

  assign fir_y = rp[LATENCY-1];

  always @(posedge clk) begin
    if (fir_rst) begin
      widx <= 0;
      for (int i = 0; i < NTAPS; i++) begin
        coef[i] <= '0;
        hist[i] <= '0;
      end
      for (int j = 0; j < LATENCY; j++) rp[j] <= '0;
    end else begin
      if (fir_load_coeff && (widx < NTAPS)) begin
        coef[widx] <= fir_coeff;
        widx       <= widx + 1;
      end
      if (fir_start) begin
        xs  = fir_x;
        acc = xs * coef[0];
        for (int i = 1; i < NTAPS; i++) acc = acc + hist[i-1] * coef[i];
        hist[0] <= xs;
        for (int i = 1; i < NTAPS; i++) hist[i] <= hist[i-1];
        rp[0] <= acc;
        for (int j = 1; j < LATENCY; j++) rp[j] <= rp[j-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [RW-1:0] obs,
                           input logic [RW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard and monitor (negedge, away from the active edge)
  // ---------------------------------------------------------------------------
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] run_sum = '0;
  int            cnt_load = 0;
  int            cnt_rst  = 0;
  int            cnt_zero = 0;
  int            beats    = 0;
  logic [RW-1:0] last_beat = '0;
  logic          prev_stall = 1'b0;
  logic [RW-1:0] prev_mdata = '0;

  always @(negedge clk) begin
    if (fir_load_coeff) cnt_load++;
    if (fir_rst) cnt_rst++;
    if (fir_start && (dbg_state == ST_FLUSH)) begin
      cnt_zero++;
      check_val("flush_x_zero", RW'(fir_x), '0);
    end
    if (bus.m_valid && !bus.m_ready) check_val("bp_no_start", RW'(fir_start), '0);
    if (prev_stall) check_val("hold_stable", bus.m_data, prev_mdata);
    if (bus.m_valid && bus.m_ready) begin
      beats++;
      last_beat = bus.m_data;
      if (exp_q.size() == 0) check_val("sb_extra_beat", RW'(exp_q.size()), RW'(1));
      else check_val("sb_data", bus.m_data, exp_q.pop_front());
    end
    prev_stall = bus.m_valid && !bus.m_ready && !rst;
    prev_mdata = bus.m_data;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_n(input int n, input logic [DW-1:0] val);
    int sent = 0;
    int cyc  = 0;
    while ((sent < n) && (cyc < 200)) begin
      bus.s_valid = 1'b1;
      bus.s_data  = val;
      #1;
      if (bus.s_ready) begin
        sent++;
        run_sum = run_sum + RW'(val);
        exp_q.push_back(run_sum);
      end
      tick();
      cyc++;
    end
    bus.s_valid = 1'b0;
    check_val("send_count", RW'(sent), RW'(n));
  endtask

  task automatic do_flush();
    int cyc = 0;
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    while (!((dbg_state == ST_RUN) && !bus.m_valid) && (cyc < 200)) begin
      tick();
      cyc++;
    end
    check_val("flush_back_run", RW'(dbg_state), RW'(ST_RUN));
    check_val("sb_drained", RW'(exp_q.size()), '0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int hs;
    int cyc;
    int b_load, b_rst, b_zero, b_beats;

    rst           = 1'b1;
    bus.cfg_go    = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_coeff = '0;
    bus.s_valid   = 1'b0;
    bus.s_data    = '0;
    bus.flush     = 1'b0;
    bus.m_ready   = 1'b0;
    repeat (3) tick();

    // Reset state
    bus.s_valid = 1'b1;
    #1;
    check_val("rst_state", RW'(dbg_state), RW'(ST_IDLE));
    check_val("rst_cfg_ready", RW'(bus.cfg_ready), '0);
    check_val("rst_s_ready", RW'(bus.s_ready), '0);
    check_val("rst_m_valid", RW'(bus.m_valid), '0);
    check_val("rst_m_data", bus.m_data, '0);
    check_val("rst_busy", RW'(bus.busy), '0);
    check_val("rst_fir_rst", RW'(fir_rst), '0);
    check_val("rst_fir_start", RW'(fir_start), '0);
    bus.s_valid = 1'b0;
    rst = 1'b0;
    tick();

    // T1: load 100 coefficients, cfg_valid gapped every 3rd cycle
    b_load = cnt_load;
    b_rst  = cnt_rst;
    bus.cfg_go = 1'b1;
    tick();
    bus.cfg_go = 1'b0;
    check_val("t1_clr", RW'(dbg_state), RW'(ST_CLR));
    tick();
    check_val("t1_load", RW'(dbg_state), RW'(ST_LOAD));
    hs  = 0;
    cyc = 0;
    while ((hs < NTAPS) && (cyc < 600)) begin
      bus.cfg_valid = ((cyc % 3) != 2);
      bus.cfg_coeff = 16'd1;
      #1;
      if (bus.cfg_valid && bus.cfg_ready) hs++;
      tick();
      cyc++;
    end
    bus.cfg_valid = 1'b0;
    check_val("t1_handshakes", RW'(hs), RW'(NTAPS));
    check_val("t1_run", RW'(dbg_state), RW'(ST_RUN));
    check_val("t1_load_pulses", RW'(cnt_load - b_load), RW'(100));
    check_val("t1_rst_pulses", RW'(cnt_rst - b_rst), RW'(1));

    // T2: 8 samples of 5 back-to-back, m_ready=1
    bus.m_ready = 1'b1;
    b_beats = beats;
    send_n(8, 16'd5);
    do_flush();
    check_val("t2_beats", RW'(beats - b_beats), RW'(8));
    check_val("t2_last", last_beat, RW'(40));

    // T3: m_ready low for 20 cycles mid-stream
    b_beats = beats;
    hs  = 0;
    cyc = 0;
    while ((hs < 12) && (cyc < 200)) begin
      bus.m_ready = !((cyc >= 6) && (cyc < 26));
      bus.s_valid = 1'b1;
      bus.s_data  = 16'd3;
      #1;
      if (cyc == 20) check_val("t3_s_ready_low", RW'(bus.s_ready), '0);
      if (bus.s_ready) begin
        hs++;
        run_sum = run_sum + RW'(3);
        exp_q.push_back(run_sum);
      end
      tick();
      cyc++;
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    check_val("t3_sent", RW'(hs), RW'(12));
    do_flush();
    check_val("t3_beats", RW'(beats - b_beats), RW'(12));
    check_val("t3_last", last_beat, RW'(76));

    // T4: 3 samples then flush
    b_beats = beats;
    b_zero  = cnt_zero;
    send_n(3, 16'd7);
    check_val("t4_busy_inflight", RW'(bus.busy), RW'(1));
    do_flush();
    check_val("t4_beats", RW'(beats - b_beats), RW'(3));
    check_val("t4_zero_pulses", RW'(cnt_zero - b_zero), RW'(LATENCY - 1));
    check_val("t4_last", last_beat, RW'(97));
    check_val("t4_busy_idle", RW'(bus.busy), '0);

    // T5: cfg_go with 2 tokens in flight is ignored
    b_beats = beats;
    b_rst   = cnt_rst;
    send_n(2, 16'd2);
    bus.cfg_go = 1'b1;
    tick();
    bus.cfg_go = 1'b0;
    check_val("t5_go_ignored", RW'(dbg_state), RW'(ST_RUN));
    do_flush();
    repeat (3) tick();
    check_val("t5_not_latched", RW'(dbg_state), RW'(ST_RUN));
    check_val("t5_no_rst", RW'(cnt_rst - b_rst), '0);
    check_val("t5_beats", RW'(beats - b_beats), RW'(2));
    check_val("t5_last", last_beat, RW'(101));
    bus.cfg_go = 1'b1;
    cyc = 0;
    while ((dbg_state != ST_CLR) && (cyc < 10)) begin
      tick();
      cyc++;
    end
    check_val("t5_clr", RW'(dbg_state), RW'(ST_CLR));
    check_val("t5_fir_rst", RW'(fir_rst), RW'(1));
    bus.cfg_go = 1'b0;
    tick();
    check_val("t5_rst_pulses", RW'(cnt_rst - b_rst), RW'(1));

    // T6: reset at coefficient 50
    hs  = 0;
    cyc = 0;
    while ((hs < 49) && (cyc < 200)) begin
      bus.cfg_valid = 1'b1;
      bus.cfg_coeff = 16'd2;
      #1;
      if (bus.cfg_ready) hs++;
      tick();
      cyc++;
    end
    check_val("t6_pre_hs", RW'(hs), RW'(49));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.s_valid = 1'b1;
    bus.s_data  = 16'd9;
    #1;
    check_val("t6_state", RW'(dbg_state), RW'(ST_IDLE));
    check_val("t6_cfg_ready", RW'(bus.cfg_ready), '0);
    check_val("t6_load_strobe", RW'(fir_load_coeff), '0);
    check_val("t6_s_ready", RW'(bus.s_ready), '0);
    check_val("t6_fir_start", RW'(fir_start), '0);
    check_val("t6_m_valid", RW'(bus.m_valid), '0);
    check_val("t6_m_data", bus.m_data, '0);
    check_val("t6_busy", RW'(bus.busy), '0);
    check_val("t6_fir_rst", RW'(fir_rst), '0);
    repeat (3) tick();
    check_val("t6_unloaded_s_ready", RW'(bus.s_ready), '0);
    check_val("t6_unloaded_idle", RW'(dbg_state), RW'(ST_IDLE));
    bus.s_valid   = 1'b0;
    bus.cfg_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
